// File: rtl/apb4_slave_mem_pkg.sv
// rtl/apb4_slave_mem_pkg.sv - shared types and helpers for the APB4 memory completer
package apb4_slave_mem_pkg;

   typedef enum logic {IDLE, ACCESS} apb_state_e;

   typedef enum logic {OKAY, SLVERR} apb_resp_t;

   localparam int PPROT_PRIV_BIT = 0;

   // Address bits below this index select a byte within one data word.
   function automatic int lsb_of(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - single-port word RAM with per-byte write enables and registered read
module apb_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [$clog2(DEPTH)-1:0]    addr_i,
   input  logic                        rd_en_i,
   input  logic [DATA_WIDTH/8-1:0]     be_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   output logic [DATA_WIDTH-1:0]       rdata_o
);

   localparam int BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < BYTES; i++) begin
         if (be_i[i]) begin
            mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (rd_en_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/apb4_slave_mem.sv
// rtl/apb4_slave_mem.sv - APB4 completer with wait states, byte strobes, privilege check and error response
module apb4_slave_mem
   import apb4_slave_mem_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 256,
   parameter int WAIT_STATES     = 0,
   parameter int PRIV_WRITE_ONLY = 1
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic [ADDR_WIDTH-1:0]     PADDR,
   input  logic [2:0]                PPROT,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [DATA_WIDTH-1:0]     PWDATA,
   input  logic [DATA_WIDTH/8-1:0]   PSTRB,
   output logic [DATA_WIDTH-1:0]     PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = lsb_of(DATA_WIDTH);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH * BYTES);

   apb_state_e             state_q;
   logic [3:0]             cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   write_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [BYTES-1:0]       strb_q;
   logic                   err_q;

   logic                   setup;
   logic                   complete;
   logic                   err_d;
   logic                   out_of_range;
   logic                   misaligned;
   logic                   priv_err;
   logic [IDX_W-1:0]       mem_addr;
   logic [BYTES-1:0]       mem_be;
   logic [DATA_WIDTH-1:0]  mem_rdata;
   apb_resp_t              resp;
   logic                   unused_prot;

   assign unused_prot = ^PPROT[2:1];

   assign setup    = (state_q == IDLE) && PSEL && !PENABLE;
   assign complete = (state_q == ACCESS) && PSEL && (cnt_q == 4'd0);

   assign out_of_range = {1'b0, PADDR} >= LIMIT;
   assign priv_err     = PWRITE && (PRIV_WRITE_ONLY != 0) && !PPROT[PPROT_PRIV_BIT];

   generate
      if (LSB > 0) begin : g_align
         assign misaligned = |PADDR[LSB-1:0];
      end else begin : g_no_align
         assign misaligned = 1'b0;
      end
   endgenerate

   assign err_d = out_of_range || misaligned || priv_err;

   // The setup read uses the live bus address; the committing write uses the captured one.
   assign mem_addr = (state_q == ACCESS) ? idx_q : PADDR[LSB +: IDX_W];
   assign mem_be   = (complete && write_q && !err_q) ? strb_q : '0;

   apb_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk_i   (PCLK),
      .rst_ni  (PRESETn),
      .addr_i  (mem_addr),
      .rd_en_i (setup && !PWRITE),
      .be_i    (mem_be),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (setup) begin
                  idx_q   <= PADDR[LSB +: IDX_W];
                  write_q <= PWRITE;
                  wdata_q <= PWDATA;
                  strb_q  <= PSTRB;
                  err_q   <= err_d;
                  cnt_q   <= 4'(WAIT_STATES);
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!PSEL) begin
                  state_q <= IDLE;
               end else if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp    = err_q ? SLVERR : OKAY;
   assign PREADY  = complete;
   assign PSLVERR = PREADY && (resp == SLVERR);
   assign PRDATA  = (PREADY && !write_q && (resp == OKAY)) ? mem_rdata : '0;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// tb/tb_apb4_slave_mem.sv - scoreboard bench for apb4_slave_mem (32-bit, 256 words, 2 and 0 wait states)
module tb_apb4_slave_mem;

   logic        clk = 1'b0;
   logic        presetn = 1'b0;
   logic [31:0] paddr = '0;
   logic [2:0]  pprot = '0;
   logic        psel_a = 1'b0;
   logic        psel_b = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;

   always #5 clk = ~clk;

   apb4_slave_mem #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2), .PRIV_WRITE_ONLY(1)
   ) u_dut_a (
      .PCLK(clk), .PRESETn(presetn), .PADDR(paddr), .PPROT(pprot), .PSEL(psel_a),
      .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
   );

   apb4_slave_mem #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0), .PRIV_WRITE_ONLY(1)
   ) u_dut_b (
      .PCLK(clk), .PRESETn(presetn), .PADDR(paddr), .PPROT(pprot), .PSEL(psel_b),
      .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_a [256];
   logic [31:0] model_b [256];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic apb_xfer(input bit tgt, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
      exp_t        e;
      logic [31:0] w;
      int          cyc;
      bit          done;
      e.err = (addr >= 32'h400) || (addr[1:0] != 2'b00) || (wr && !prot[0]);
      e.lat = tgt ? 1 : 3;
      e.rdata = '0;
      if (!e.err) begin
         w = tgt ? model_b[addr[9:2]] : model_a[addr[9:2]];
         if (wr) begin
            for (int i = 0; i < 4; i++) if (strb[i]) w[i*8 +: 8] = data[i*8 +: 8];
            if (tgt) model_b[addr[9:2]] = w; else model_a[addr[9:2]] = w;
         end else begin
            e.rdata = w;
         end
      end
      sb.push_back(e);

      @(posedge clk) #1;
      psel_a = !tgt; psel_b = tgt; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
      @(posedge clk) #1;
      penable = 1'b1;
      paddr = addr ^ 32'h4; pwdata = ~data; pstrb = ~strb;
      cyc = 0;
      done = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (tgt ? pready_b : pready_a) done = 1;
      end
      e = sb.pop_front();
      chk("ready_seen", done, 1);
      chk("latency", cyc, e.lat);
      chk("pslverr", tgt ? pslverr_b : pslverr_a, e.err);
      chk("prdata", tgt ? prdata_b : prdata_a, e.rdata);
   endtask

   task automatic bus_idle();
      @(posedge clk) #1;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_pready", pready_a, 0);
      chk("rst_pslverr", pslverr_a, 0);
      chk("rst_prdata", prdata_a, 0);
      @(posedge clk) #1;
      presetn = 1'b1;

      apb_xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001);
      apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 1, 32'h10, 32'h11223344, 4'b0101, 3'b001);
      apb_xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b001);
      chk("partial_model", model_a[4], 32'hDE22BE44);
      apb_xfer(0, 1, 32'h400, 32'h12345678, 4'hF, 3'b001);
      apb_xfer(0, 0, 32'h400, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 0, 32'h12, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 1, 32'h10, 32'hCAFEF00D, 4'hF, 3'b000);
      apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000);
      apb_xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 3'b001);
      apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 1, 32'h3FC, 32'hA5A55A5A, 4'hF, 3'b011);
      apb_xfer(0, 0, 32'h3FC, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 0, 32'h3FD, 32'h0, 4'h0, 3'b001);
      apb_xfer(0, 1, 32'h20, 32'h5A5A1234, 4'hF, 3'b001);
      bus_idle();

      // Reset lands while the write to 0x20 is on its completion cycle.
      @(posedge clk) #1;
      psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
      pwdata = 32'hFFFF0000; pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk) #1;
      penable = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_pready", pready_a, 1);
      #1 presetn = 1'b0;
      #1;
      chk("midrst_pready", pready_a, 0);
      chk("midrst_pslverr", pslverr_a, 0);
      chk("midrst_prdata", prdata_a, 0);
      @(posedge clk) #1;
      psel_a = 1'b0; penable = 1'b0;
      @(posedge clk) #1;
      presetn = 1'b1;
      apb_xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001);

      apb_xfer(0, 1, 32'h30, 32'h600DF00D, 4'hF, 3'b001);
      bus_idle();
      @(posedge clk) #1;
      psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
      pwdata = 32'h0BADBEEF; pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk) #1;
      penable = 1'b1;
      @(negedge clk);
      chk("abort_wait_pready", pready_a, 0);
      @(posedge clk) #1;
      psel_a = 1'b0; penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_pready", pready_a, 0);
      end
      apb_xfer(0, 0, 32'h30, 32'h0, 4'h0, 3'b001);
      bus_idle();

      apb_xfer(1, 1, 32'h40, 32'h01020304, 4'hF, 3'b001);
      apb_xfer(1, 1, 32'h44, 32'hF0E0D0C0, 4'hF, 3'b001);
      apb_xfer(1, 0, 32'h40, 32'h0, 4'h0, 3'b001);
      apb_xfer(1, 0, 32'h44, 32'h0, 4'h0, 3'b000);
      apb_xfer(1, 0, 32'h400, 32'h0, 4'h0, 3'b001);
      bus_idle();
      repeat (2) @(negedge clk);
      chk("final_idle_pready", pready_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
